// File: rtl/reg_file_sb_if.sv
// Register-file bus: write port, two read ports with pending flags, claim and clear control.
// The master drives addresses/data/control; the slave (reg_file_sb) returns read data and status.
interface reg_file_sb_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3
);
    logic              we;
    logic [ADDR_W-1:0] W_Adr;
    logic [DATA_W-1:0] W;
    logic [ADDR_W-1:0] R_Adr;
    logic [ADDR_W-1:0] S_Adr;
    logic [DATA_W-1:0] R;
    logic [DATA_W-1:0] S;
    logic              claim;
    logic [ADDR_W-1:0] claim_adr;
    logic              r_pend;
    logic              s_pend;
    logic              clr;
    logic              clr_busy;
    logic              clr_done;

    modport master (
        output we, W_Adr, W, R_Adr, S_Adr, claim, claim_adr, clr,
        input  R, S, r_pend, s_pend, clr_busy, clr_done
    );

    modport slave (
        input  we, W_Adr, W, R_Adr, S_Adr, claim, claim_adr, clr,
        output R, S, r_pend, s_pend, clr_busy, clr_done
    );
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register pending scoreboard and a sequenced clear engine.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data onto the read ports.
module reg_file_sb #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic         clk,
    input  logic         reset,
    reg_file_sb_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [ADDR_W-1:0] clr_cnt_reg;
    logic [ADDR_W-1:0] clr_cnt_next;

    logic idle;
    logic clearing;
    logic clr_start;
    logic last_clear;

    assign idle       = (state_reg == ST_IDLE);
    assign clearing   = (state_reg == ST_CLEAR);
    assign clr_start  = idle && bus.clr;
    assign last_clear = clearing && (clr_cnt_reg == ADDR_W'(DEPTH - 1));

    // Clear sequencer: one register zeroed per CLEAR cycle, then a single DONE cycle.
    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.clr) begin
                    state_next   = ST_CLEAR;
                    clr_cnt_next = '0;
                end
            end
            ST_CLEAR: begin
                if (last_clear) begin
                    state_next = ST_DONE;
                end else begin
                    clr_cnt_next = clr_cnt_reg + 1'b1;
                end
            end
            ST_DONE: begin
                state_next   = ST_IDLE;
                clr_cnt_next = '0;
            end
            default: begin
                state_next   = ST_IDLE;
                clr_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            clr_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
        end
    end

    assign bus.clr_busy = clearing;
    assign bus.clr_done = (state_reg == ST_DONE);

    logic [DATA_W-1:0] reg_q [DEPTH];
    logic [DEPTH-1:0]  pend_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            if (ZERO_R0 != 0 && gi == 0) begin : g_zero
                assign reg_q[gi]  = '0;
                assign pend_q[gi] = 1'b0;
            end else begin : g_reg
                localparam logic [ADDR_W-1:0] ADR = ADDR_W'(gi);

                logic [DATA_W-1:0] data_reg;
                logic              pend_reg;
                logic              wr_hit;
                logic              claim_hit;
                logic              clr_hit;

                assign wr_hit    = idle && bus.we && (bus.W_Adr == ADR);
                assign claim_hit = idle && bus.claim && (bus.claim_adr == ADR);
                assign clr_hit   = clearing && (clr_cnt_reg == ADR);

                always_ff @(posedge clk) begin
                    if (reset) begin
                        data_reg <= '0;
                        pend_reg <= 1'b0;
                    end else begin
                        if (wr_hit) begin
                            data_reg <= bus.W;
                        end else if (clr_hit) begin
                            data_reg <= '0;
                        end
                        // A claim in the same cycle as a write to this entry keeps it pending.
                        if (clr_start) begin
                            pend_reg <= 1'b0;
                        end else if (claim_hit) begin
                            pend_reg <= 1'b1;
                        end else if (wr_hit) begin
                            pend_reg <= 1'b0;
                        end
                    end
                end

                assign reg_q[gi]  = data_reg;
                assign pend_q[gi] = pend_reg;
            end
        end
    endgenerate

`ifdef REG_FILE_BYPASS_EN
    logic byp_r;
    logic byp_s;
    logic claim_r;
    logic claim_s;

    // Hardwired zero register is never forwarded.
    assign byp_r   = idle && bus.we && (bus.W_Adr == bus.R_Adr) &&
                     !(ZERO_R0 != 0 && bus.R_Adr == '0);
    assign byp_s   = idle && bus.we && (bus.W_Adr == bus.S_Adr) &&
                     !(ZERO_R0 != 0 && bus.S_Adr == '0);
    assign claim_r = idle && bus.claim && (bus.claim_adr == bus.R_Adr);
    assign claim_s = idle && bus.claim && (bus.claim_adr == bus.S_Adr);

    always_comb begin
        bus.R      = reg_q[bus.R_Adr];
        bus.S      = reg_q[bus.S_Adr];
        bus.r_pend = pend_q[bus.R_Adr];
        bus.s_pend = pend_q[bus.S_Adr];
        if (byp_r) begin
            bus.R      = bus.W;
            bus.r_pend = claim_r;
        end
        if (byp_s) begin
            bus.S      = bus.W;
            bus.s_pend = claim_s;
        end
    end
`else
    always_comb begin
        bus.R      = reg_q[bus.R_Adr];
        bus.S      = reg_q[bus.S_Adr];
        bus.r_pend = pend_q[bus.R_Adr];
        bus.s_pend = pend_q[bus.S_Adr];
    end
`endif

endmodule
